// File: rtl/fixed_point_pkg.sv
// Shared types and helpers for the fixed-point result stage.
// Holds the skid-buffer state encoding, the buffered entry layout and the
// saturation limits. Entries carry a MAX_N-wide data field; users keep only the low N bits.
package fixed_point_pkg;

  // Widest data path any instance may use. The entry struct is sized to it
  // because a package typedef cannot follow a module parameter.
  localparam int MAX_N = 64;

  // Occupancy of the two-entry skid buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  // One buffered word. Overflow is captured alongside the data so it always
  // describes the word it travels with.
  typedef struct packed {
    logic [MAX_N-1:0] data;
    logic             carry;
    logic             ovf;
  } entry_t;

  // Largest positive two's-complement value for an n-bit word: 0111...1.
  function automatic logic [MAX_N-1:0] sat_pos_limit(input int n);
    return (MAX_N'(1) << (n - 1)) - MAX_N'(1);
  endfunction

  // Most negative two's-complement value for an n-bit word: 1000...0.
  function automatic logic [MAX_N-1:0] sat_neg_limit(input int n);
    return MAX_N'(1) << (n - 1);
  endfunction

endpackage

// File: rtl/fixed_point_saturate.sv
// Purely combinational clamp of the subtractor difference on signed overflow.
// Clamping is compiled in only when FIXED_POINT_SATURATE_EN is defined;
// otherwise the wrapped difference passes through unchanged.
module fixed_point_saturate
  import fixed_point_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] diff,
  input  logic         b_sign,
  input  logic         ovf,
  output logic [N-1:0] data
);

`ifdef FIXED_POINT_SATURATE_EN
  // On overflow the true result lies beyond the range on the minuend's side,
  // so clamp towards the limit that matches the sign of b.
  always_comb begin
    data = diff;
    if (ovf) begin
      data = b_sign ? N'(sat_neg_limit(N)) : N'(sat_pos_limit(N));
    end
  end
`else
  // Wrapping build: the control inputs have no effect on the data.
  logic unused_ctl;
  assign unused_ctl = b_sign ^ ovf;
  assign data       = diff;
`endif

endmodule

// File: rtl/fixed_point_result_stage.sv
// Registers a subtractor result through a 2-entry skid buffer, flags signed overflow, counts overflow events.
// Latency 1 cycle from accept to out_valid; 1 word/cycle sustained while out_ready=1.
// in_ready is a register (state != FULL); build with FIXED_POINT_SATURATE_EN to clamp overflowed words.
module fixed_point_result_stage
  import fixed_point_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     diff,
  input  logic             carry_out,
  input  logic             a_sign,
  input  logic             b_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     result,
  output logic             carry,
  output logic             overflow,
  input  logic             clr_count,
  output logic [CNT_W-1:0] ovf_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  buf_state_t       state_q;
  buf_state_t       state_d;
  entry_t           out_q;
  entry_t           skid_q;
  entry_t           in_entry;
  logic             in_ready_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N-1:0]     sat_data;
  logic             in_ovf;
  logic             accept;
  logic             emit;
  logic             load_out_new;
  logic             load_out_skid;
  logic             load_skid;

  // Signed overflow of b - a: operands differ in sign and the difference
  // came out with the sign opposite to the minuend.
  assign in_ovf = (a_sign != b_sign) && (diff[N-1] != b_sign);

  fixed_point_saturate #(.N(N)) u_saturate (
    .diff   (diff),
    .b_sign (b_sign),
    .ovf    (in_ovf),
    .data   (sat_data)
  );

  // Assemble the word to be captured; unused upper data bits stay zero.
  always_comb begin
    in_entry              = '0;
    in_entry.data[N-1:0]  = sat_data;
    in_entry.carry        = carry_out;
    in_entry.ovf          = in_ovf;
  end

  // Handshakes. in_ready_q is low in FULL, so nothing is accepted there.
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready_q;
  assign emit      = out_valid && out_ready;

  // Next-state and buffer load decisions from the current occupancy.
  always_comb begin
    state_d       = state_q;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d      = ONE;
          load_out_new = 1'b1;
        end
      end
      ONE: begin
        case ({accept, emit})
          2'b10: begin
            // Consumer stalled: park the new word in the skid slot.
            state_d   = FULL;
            load_skid = 1'b1;
          end
          2'b01: begin
            state_d = EMPTY;
          end
          2'b11: begin
            // Pass-through: the output register is refilled in place.
            load_out_new = 1'b1;
          end
          default: begin
            state_d = ONE;
          end
        endcase
      end
      FULL: begin
        if (emit) begin
          state_d       = ONE;
          load_out_skid = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State register plus registered in_ready, which never sees out_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  // Output and skid registers; both entries are dropped on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out_new) begin
        out_q <= in_entry;
      end else if (load_out_skid) begin
        out_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_entry;
      end
    end
  end

  // Saturating overflow event counter; clear takes priority over a count.
  always_ff @(posedge clk) begin
    if (rst || clr_count) begin
      cnt_q <= '0;
    end else if (accept && in_ovf && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Upper data bits of the shared entry layout are constant zero here.
  if (N < MAX_N) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^{out_q.data[MAX_N-1:N], skid_q.data[MAX_N-1:N]};
  end

  assign in_ready  = in_ready_q;
  assign result    = out_q.data[N-1:0];
  assign carry     = out_q.carry;
  assign overflow  = out_q.ovf;
  assign ovf_count = cnt_q;

endmodule

// File: tb/tb_fixed_point_result_stage.sv
// Self-checking bench for fixed_point_result_stage at N=8, CNT_W=4.
// A queue-based occupancy model predicts every cycle; directed tables and
// sequences cover latency, overflow, backpressure, counter limits and reset.
module tb_fixed_point_result_stage;

  localparam int N     = 8;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     diff;
  logic             carry_out;
  logic             a_sign;
  logic             b_sign;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     result;
  logic             carry;
  logic             overflow;
  logic             clr_count;
  logic [CNT_W-1:0] ovf_count;

  always #5 clk = ~clk;

  fixed_point_result_stage #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .diff      (diff),
    .carry_out (carry_out),
    .a_sign    (a_sign),
    .b_sign    (b_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .clr_count (clr_count),
    .ovf_count (ovf_count)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [N-1:0] data;
    logic         c;
    logic         o;
  } mentry_t;

  mentry_t mq[$];
  int      m_count;

  typedef struct {
    logic [N-1:0] diff;
    logic         a;
    logic         b;
    logic         c;
    logic [N-1:0] res_wrap;
    logic [N-1:0] res_sat;
    logic         ovf;
    int           cnt;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Expected word from the arithmetic meaning: signed overflow of b - a.
  function automatic mentry_t model_word(input logic [N-1:0] d, input logic a,
                                         input logic b, input logic c);
    mentry_t e;
    e.o    = (a != b) && (d[N-1] != b);
    e.c    = c;
    e.data = d;
`ifdef FIXED_POINT_SATURATE_EN
    if (e.o) e.data = b ? 8'h80 : 8'h7F;
`endif
    return e;
  endfunction

  // One clock: update the FIFO model from the applied inputs, then compare.
  task automatic step();
    bit      acc;
    bit      emi;
    mentry_t w;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_count = 0;
    end else begin
      acc = in_valid && (mq.size() < 2);
      emi = out_ready && (mq.size() > 0);
      w   = model_word(diff, a_sign, b_sign, carry_out);
      if (clr_count) m_count = 0;
      else if (acc && w.o && m_count < CMAX) m_count++;
      if (emi) void'(mq.pop_front());
      if (acc) mq.push_back(w);
    end
    #1;
    chk("out_valid", int'(out_valid), int'(mq.size() > 0));
    chk("in_ready", int'(in_ready), int'(mq.size() < 2));
    chk("ovf_count", int'(ovf_count), m_count);
    if (mq.size() > 0) begin
      chk("result", int'(result), int'(mq[0].data));
      chk("carry", int'(carry), int'(mq[0].c));
      chk("overflow", int'(overflow), int'(mq[0].o));
    end
  endtask

  initial begin
    tbl[0] = '{8'h05, 1'b0, 1'b0, 1'b0, 8'h05, 8'h05, 1'b0, 0};
    tbl[1] = '{8'h81, 1'b1, 1'b0, 1'b1, 8'h81, 8'h7F, 1'b1, 1};
    tbl[2] = '{8'h7F, 1'b0, 1'b1, 1'b0, 8'h7F, 8'h80, 1'b1, 2};
    tbl[3] = '{8'h90, 1'b0, 1'b1, 1'b1, 8'h90, 8'h90, 1'b0, 2};
    tbl[4] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0, 2};
    tbl[5] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 2};

    rst = 1'b1; in_valid = 1'b1; diff = 8'hAA; carry_out = 1'b1;
    a_sign = 1'b1; b_sign = 1'b0; out_ready = 1'b1; clr_count = 1'b0;
    step();
    step();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_result", int'(result), 0);
    chk("rst_carry", int'(carry), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_count", int'(ovf_count), 0);
    rst = 1'b0; in_valid = 1'b0;
    step();

    // Single accepts from EMPTY: 1-cycle latency and overflow decode.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; diff = tbl[i].diff; a_sign = tbl[i].a;
      b_sign = tbl[i].b; carry_out = tbl[i].c;
      step();
      in_valid = 1'b0;
      chk("tbl_valid", int'(out_valid), 1);
`ifdef FIXED_POINT_SATURATE_EN
      chk("tbl_result", int'(result), int'(tbl[i].res_sat));
`else
      chk("tbl_result", int'(result), int'(tbl[i].res_wrap));
`endif
      chk("tbl_overflow", int'(overflow), int'(tbl[i].ovf));
      chk("tbl_carry", int'(carry), int'(tbl[i].c));
      chk("tbl_count", int'(ovf_count), tbl[i].cnt);
      step();
      chk("tbl_drained", int'(out_valid), 0);
    end

    // Backpressure: third word must be refused, order preserved.
    out_ready = 1'b0; in_valid = 1'b1; a_sign = 1'b0; b_sign = 1'b0;
    diff = 8'h11; step();
    chk("bp_ready_one", int'(in_ready), 1);
    diff = 8'h22; step();
    chk("bp_ready_full", int'(in_ready), 0);
    chk("bp_hold_11", int'(result), 8'h11);
    diff = 8'h33; step();
    chk("bp_still_11", int'(result), 8'h11);
    chk("bp_still_full", int'(in_ready), 0);
    in_valid = 1'b0; out_ready = 1'b1; step();
    chk("bp_emit_22_vld", int'(out_valid), 1);
    chk("bp_emit_22", int'(result), 8'h22);
    step();
    chk("bp_no_33", int'(out_valid), 0);

    // Counter saturation and clear priority.
    clr_count = 1'b1; step(); clr_count = 1'b0;
    chk("cnt_cleared", int'(ovf_count), 0);
    in_valid = 1'b1; diff = 8'h81; a_sign = 1'b1; b_sign = 1'b0;
    repeat (17) step();
    chk("cnt_sat", int'(ovf_count), CMAX);
    step();
    chk("cnt_hold", int'(ovf_count), CMAX);
    clr_count = 1'b1; step(); clr_count = 1'b0;
    chk("cnt_clr_wins", int'(ovf_count), 0);
    in_valid = 1'b0; step();

    // Reset while FULL drops both entries and any word offered during reset.
    out_ready = 1'b0; in_valid = 1'b1; diff = 8'h44; a_sign = 1'b0; b_sign = 1'b0;
    step();
    diff = 8'h81; a_sign = 1'b1; step();
    chk("mid_full", int'(in_ready), 0);
    chk("mid_cnt_pre", int'(ovf_count), 1);
    rst = 1'b1; diff = 8'h66; a_sign = 1'b0; step();
    rst = 1'b0; in_valid = 1'b0;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_ready", int'(in_ready), 1);
    chk("mid_rst_count", int'(ovf_count), 0);
    out_ready = 1'b1;
    repeat (3) step();
    chk("mid_no_stale", int'(out_valid), 0);

    // Streaming: 100 random words with no bubbles.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      diff = N'($urandom); a_sign = 1'($urandom); b_sign = 1'($urandom);
      carry_out = 1'($urandom);
      step();
      chk("stream_no_bubble", int'(out_valid), 1);
    end
    in_valid = 1'b0; step();

    // Random handshakes, occasional clears.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_count = ($urandom_range(0, 15) == 0);
      diff = N'($urandom); a_sign = 1'($urandom); b_sign = 1'($urandom);
      carry_out = 1'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fixed_point_result_stage.md
FIXED_POINT_RESULT_STAGE -- requirements
Module: fixed_point_result_stage

Interface
REQ-001 Parameter N, default 32: data path width in bits; SHALL match the upstream FixedPointSubtract N.
REQ-002 Parameter CNT_W, default 16: overflow event counter width in bits.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  the upstream subtract result is valid.
REQ-006 in_ready  output  1  the stage can accept an input this cycle.
REQ-007 diff  input  N  difference word from the upstream subtractor `c`.
REQ-008 carry_out  input  1  upstream carry-out; passed through with the data.
REQ-009 a_sign  input  1  MSB of subtrahend operand a.
REQ-010 b_sign  input  1  MSB of minuend operand b.
REQ-011 out_valid  output  1  result holds valid data.
REQ-012 out_ready  input  1  the downstream consumer accepts result.
REQ-013 result  output  N  registered, optionally saturated, difference.
REQ-014 carry  output  1  registered carry_out that matches result.
REQ-015 overflow  output  1  signed overflow flag that matches result.
REQ-016 clr_count  input  1  synchronous clear of ovf_count.
REQ-017 ovf_count  output  CNT_W  number of accepted overflowing inputs, saturating.

Function
REQ-018 Accept SHALL occur when in_valid && in_ready; emit SHALL occur when out_valid && out_ready.
REQ-019 The stage SHALL be a 2-entry skid buffer with states EMPTY, ONE and FULL.
  - EMPTY + accept -> ONE.
  - ONE + accept without emit -> FULL.
  - ONE + emit without accept -> EMPTY.
  - ONE + accept and emit -> ONE.
  - FULL + emit -> ONE, with the skid entry moving to the output register.
REQ-020 in_ready SHALL be registered, SHALL equal (state != FULL), and SHALL have no combinational path from out_ready.
REQ-021 Latency from accept into EMPTY to out_valid SHALL be 1 cycle.
REQ-022 Throughput SHALL be 1 word per cycle while out_ready=1.
REQ-023 result, carry and overflow SHALL stay stable while out_valid && !out_ready.
REQ-024 Overflow SHALL be computed at accept as ovf = (a_sign != b_sign) && (diff[N-1] != b_sign), and SHALL be stored with the word.
REQ-025 On each accept with ovf=1, ovf_count SHALL increment by 1 and SHALL hold at all-ones with no wrap.
REQ-026 When clr_count and an overflowing accept occur in the same cycle, clr_count SHALL win and ovf_count SHALL become 0.
REQ-027 In FULL state, in_valid SHALL be ignored: no capture and no count.

Reset
REQ-028 While rst=1 at a clock edge, the following SHALL hold:
  - state=EMPTY
  - out_valid=0, result=0, carry=0, overflow=0
  - ovf_count=0
  - in_ready=1
REQ-029 Reset mid-operation SHALL discard both buffered entries with no emit.
REQ-030 Inputs presented in the reset cycle SHALL be dropped.

Configuration
REQ-031 Macro FIXED_POINT_SATURATE_EN SHALL select the overflow behaviour.
  - Defined: a word with ovf=1 SHALL be replaced at capture by {1'b0,{N-1{1'b1}}} when b_sign=0, or by {1'b1,{N-1{1'b0}}} when b_sign=1.
  - Undefined: diff SHALL pass through wrapped.
  - In both cases overflow and ovf_count behave identically.

Structure
REQ-032 A shared package fixed_point_pkg SHALL hold:
  - the buffer state enum (EMPTY/ONE/FULL);
  - a packed entry struct {data, carry, ovf};
  - saturation-limit functions of N.
REQ-033 A sub-module fixed_point_saturate SHALL be the natural split: combinational, N-parameterised, taking diff, b_sign and ovf and returning the saturated data.
REQ-034 FixedPointSubtract SHALL NOT be instantiated inside this block; it connects at the parent level.

Verification (N=8, CNT_W=4)
REQ-035 Basic latency and hold:
  - Stimulus: EMPTY, out_ready=1, accept diff=0x05, a_sign=0, b_sign=0.
  - Response: next cycle out_valid=1, result=0x05, overflow=0; ovf_count stays 0.
REQ-036 Positive overflow:
  - Stimulus: accept diff=0x81, a_sign=1, b_sign=0.
  - Response: overflow=1, ovf_count=1.
  - With FIXED_POINT_SATURATE_EN: result=0x7F. Without it: result=0x81.
REQ-037 Backpressure and ordering:
  - Stimulus: out_ready=0, accept 0x11, 0x22, 0x33 on consecutive cycles.
  - Response: in_ready=0 after the 2nd accept and 0x33 is not captured; raising out_ready emits 0x11 then 0x22 in order.
REQ-038 Counter saturation and clear priority:
  - Stimulus: 17 overflowing accepts.
  - Response: ovf_count=0xF and holds.
  - Then clr_count=1 together with an overflowing accept -> ovf_count=0.
REQ-039 Reset mid-operation:
  - Stimulus: in FULL state, rst=1 for 1 cycle.
  - Response: next cycle out_valid=0, in_ready=1, ovf_count=0, no stale word emitted afterwards.
REQ-040 Streaming:
  - Stimulus: continuous in_valid, out_ready=1, 100 random words.
  - Response: outputs match a reference model 1 cycle later with no bubbles.
